wbm_dma: RTL

Wishbone bus initiator that copies a block of 16-bit words from one address range to another, or fills a range with a constant pattern, on behalf of a control register block. It drives the initiator side of the 16-bit Wishbone bus that the on-chip memory and peripherals respond to. The bus is shared with no other initiator, so no arbitration is required. It transfers one word per bus cycle and has no internal buffering beyond a single data holding register.

---
 rtl/wbm_dma.sv | 102 ++++++++++
 1 files changed

// File: rtl/wbm_dma.sv
// wbm_dma: Wishbone initiator that block-copies or pattern-fills 16-bit words, one word per bus cycle.
// Optional ack timeout with sticky error flag when WBM_DMA_TIMEOUT_EN is defined.
module wbm_dma #(
  parameter int unsigned TMO = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        start_i,
  input  logic [15:0] src_i,
  input  logic [15:0] dst_i,
  input  logic [12:0] len_i,
  input  logic        fill_i,
  input  logic [15:0] pattern_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, DONE} state_t;
  state_t      state;
  logic [15:0] src, dst, pat, hold;
  logic [12:0] cnt;
  logic        fill;
  // Every bus output is a pure decode of the state register, so ack never reaches an output combinationally.
  assign wb_cyc_o = state == RD || state == WR;
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = state == WR;
  assign wb_sel_o = wb_cyc_o ? 2'b11 : 2'b00;
  assign wb_adr_o = state == RD ? src : state == WR ? dst : 16'h0000;
  assign wb_dat_o = state == WR ? (fill ? pat : hold) : 16'h0000;
  assign busy_o   = state == RD || state == RGAP || state == WR || state == WGAP;
  assign done_o   = state == DONE;
`ifdef WBM_DMA_TIMEOUT_EN
  localparam logic [15:0] TMO_M1 = 16'(TMO - 1);
  logic [15:0] tmo;
  logic        err;
  assign err_o = err;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) tmo <= '0;
    else tmo <= (state == RD || state == WR) && !wb_ack_i ? tmo + 16'd1 : 16'd0;
`else
  assign err_o = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      pat   <= '0;
      hold  <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
`ifdef WBM_DMA_TIMEOUT_EN
      err   <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (start_i) begin
          src   <= src_i & 16'hFFFE;
          dst   <= dst_i & 16'hFFFE;
          cnt   <= len_i;
          fill  <= fill_i;
          pat   <= pattern_i;
          state <= len_i == 13'd0 ? DONE : fill_i ? WR : RD;
`ifdef WBM_DMA_TIMEOUT_EN
          err   <= 1'b0;
`endif
        end
        RD: if (wb_ack_i) begin
          hold  <= wb_dat_i;
          state <= RGAP;
        end
`ifdef WBM_DMA_TIMEOUT_EN
        else if (tmo == TMO_M1) begin
          err   <= 1'b1;
          state <= DONE;
        end
`endif
        RGAP: state <= WR;
        WR: if (wb_ack_i) begin
          cnt   <= cnt - 13'd1;
          src   <= src + 16'd2;
          dst   <= dst + 16'd2;
          state <= WGAP;
        end
`ifdef WBM_DMA_TIMEOUT_EN
        else if (tmo == TMO_M1) begin
          err   <= 1'b1;
          state <= DONE;
        end
`endif
        WGAP: state <= cnt == 13'd0 ? DONE : fill ? WR : RD;
        default: state <= IDLE;
      endcase
endmodule
